// File: rtl/afifo_tb_pkg.sv
`default_nettype none
// ============================================================================
// Module      : afifo_tb_pkg
// Description : Shared word width, data type and skid-buffer occupancy states
// Revision    : 1.0 - initial release
// ============================================================================
package afifo_tb_pkg;

    localparam int DATA_WIDTH = 8;
    localparam int RD_CNT_W   = 16;

    typedef logic [DATA_WIDTH-1:0] afifo_data_t;

    typedef enum logic [1:0] {
        OCC_EMPTY = 2'd0,
        OCC_ONE   = 2'd1,
        OCC_FULL  = 2'd2
    } skid_occ_e;

endpackage
`default_nettype wire

// File: rtl/afifo_skid_buf2.sv
`default_nettype none
// ============================================================================
// Module      : afifo_skid_buf2
// Description : Two-entry valid/ready skid buffer (push side / pop side)
// Revision    : 1.0 - initial release
// ============================================================================
module afifo_skid_buf2
    import afifo_tb_pkg::*;
#(
    parameter int WIDTH = DATA_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] din,
    input  logic             pop,
    output logic [1:0]       occ,
    output logic [WIDTH-1:0] dout
);

    skid_occ_e        r_occ;
    skid_occ_e        w_occ_nxt;
    logic [WIDTH-1:0] r_head;
    logic [WIDTH-1:0] r_tail;
    logic [WIDTH-1:0] w_head_nxt;
    logic [WIDTH-1:0] w_tail_nxt;
    logic             w_pop;
    logic             w_push;

    // A push into a full buffer is only legal when the head leaves the same cycle.
    assign w_pop  = pop && (r_occ != OCC_EMPTY);
    assign w_push = push && ((r_occ != OCC_FULL) || w_pop);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_occ  <= OCC_EMPTY;
            r_head <= '0;
            r_tail <= '0;
        end else begin
            r_occ  <= w_occ_nxt;
            r_head <= w_head_nxt;
            r_tail <= w_tail_nxt;
        end
    end

    always_comb begin
        w_occ_nxt  = r_occ;
        w_head_nxt = r_head;
        w_tail_nxt = r_tail;
        case (r_occ)
            OCC_EMPTY: begin
                if (w_push) begin
                    w_occ_nxt  = OCC_ONE;
                    w_head_nxt = din;
                end
            end
            OCC_ONE: begin
                if (w_push && w_pop) begin
                    w_head_nxt = din;
                end else if (w_push) begin
                    w_occ_nxt  = OCC_FULL;
                    w_tail_nxt = din;
                end else if (w_pop) begin
                    w_occ_nxt  = OCC_EMPTY;
                end
            end
            OCC_FULL: begin
                if (w_pop) begin
                    w_head_nxt = r_tail;
                    if (w_push) begin
                        w_tail_nxt = din;
                    end else begin
                        w_occ_nxt  = OCC_ONE;
                    end
                end
            end
            default: begin
                w_occ_nxt = OCC_EMPTY;
            end
        endcase
    end

    assign occ  = r_occ;
    assign dout = r_head;

endmodule
`default_nettype wire

// File: rtl/afifo_rd_stream_adapter.sv
`default_nettype none
// ============================================================================
// Module      : afifo_rd_stream_adapter
// Description : Async-FIFO read-end consumer: throttled pops into a skid-buffered
//               valid/ready stream, with pop counter and incrementing-pattern checker
// Revision    : 1.0 - initial release
// ============================================================================
module afifo_rd_stream_adapter
    import afifo_tb_pkg::*;
#(
    parameter int                    DATA_WIDTH = afifo_tb_pkg::DATA_WIDTH,
    parameter int                    CNT_W      = RD_CNT_W,
    parameter int                    GAP_W      = 4,
    parameter logic [DATA_WIDTH-1:0] CHK_SEED   = '0
) (
    input  logic                  rclk,
    input  logic                  rrst,
    input  logic                  rempty,
    input  logic [DATA_WIDTH-1:0] rdata,
    output logic                  rinc,
    output logic                  m_valid,
    output logic [DATA_WIDTH-1:0] m_data,
    input  logic                  m_ready,
    input  logic                  throttle_en,
    input  logic [GAP_W-1:0]      throttle_gap,
    input  logic                  chk_en,
    input  logic                  clr,
    output logic [CNT_W-1:0]      rd_count,
    output logic                  chk_err
);

    logic [1:0]            w_occ;
    logic                  w_accept;
    logic [GAP_W-1:0]      r_gap;
    logic [CNT_W-1:0]      r_cnt;
    logic [DATA_WIDTH-1:0] r_exp;
    logic                  r_err;

    // Occupancy is registered, so rinc never depends combinationally on m_ready.
    assign rinc     = !rrst && !rempty && (r_gap == '0) && (w_occ < 2'd2);
    assign m_valid  = (w_occ != 2'd0);
    assign w_accept = m_valid && m_ready;

    afifo_skid_buf2 #(
        .WIDTH (DATA_WIDTH)
    ) u_skid (
        .clk  (rclk),
        .rst  (rrst),
        .push (rinc),
        .din  (rdata),
        .pop  (w_accept),
        .occ  (w_occ),
        .dout (m_data)
    );

    always_ff @(posedge rclk or posedge rrst) begin
        if (rrst) begin
            r_gap <= '0;
        end else if (rinc && throttle_en) begin
            r_gap <= throttle_gap;
        end else if (r_gap != '0) begin
            r_gap <= r_gap - 1'b1;
        end
    end

    // A clear takes precedence: a pop in the same cycle is neither counted nor checked.
    always_ff @(posedge rclk or posedge rrst) begin
        if (rrst) begin
            r_cnt <= '0;
            r_exp <= CHK_SEED;
            r_err <= 1'b0;
        end else if (clr) begin
            r_cnt <= '0;
            r_exp <= CHK_SEED;
            r_err <= 1'b0;
        end else if (rinc) begin
            r_cnt <= r_cnt + 1'b1;
            r_exp <= r_exp + 1'b1;
            if (chk_en && (rdata != r_exp)) begin
                r_err <= 1'b1;
            end
        end
    end

    assign rd_count = r_cnt;
    assign chk_err  = r_err;

endmodule
`default_nettype wire

// File: tb/tb_afifo_rd_stream_adapter.sv
`default_nettype none
// ============================================================================
// Module      : tb_afifo_rd_stream_adapter
// Description : Self-checking bench: queue-based FIFO source and behavioural model
// Revision    : 1.0 - initial release
// ============================================================================
module tb_afifo_rd_stream_adapter;
    import afifo_tb_pkg::*;

    localparam int C_CNT_W = 4;
    localparam int C_GAP_W = 4;

    logic                  rclk = 1'b0;
    logic                  rrst = 1'b0;
    logic                  rempty = 1'b1;
    logic [DATA_WIDTH-1:0] rdata = '0;
    logic                  rinc;
    logic                  m_valid;
    logic [DATA_WIDTH-1:0] m_data;
    logic                  m_ready = 1'b0;
    logic                  throttle_en = 1'b0;
    logic [C_GAP_W-1:0]    throttle_gap = '0;
    logic                  chk_en = 1'b0;
    logic                  clr = 1'b0;
    logic [C_CNT_W-1:0]    rd_count;
    logic                  chk_err;

    afifo_rd_stream_adapter #(
        .DATA_WIDTH (DATA_WIDTH),
        .CNT_W      (C_CNT_W),
        .GAP_W      (C_GAP_W),
        .CHK_SEED   ('0)
    ) dut (
        .rclk         (rclk),
        .rrst         (rrst),
        .rempty       (rempty),
        .rdata        (rdata),
        .rinc         (rinc),
        .m_valid      (m_valid),
        .m_data       (m_data),
        .m_ready      (m_ready),
        .throttle_en  (throttle_en),
        .throttle_gap (throttle_gap),
        .chk_en       (chk_en),
        .clr          (clr),
        .rd_count     (rd_count),
        .chk_err      (chk_err)
    );

    always #5 rclk = ~rclk;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    // FIFO source: head word visible as rdata, popped one edge after rinc is seen high.
    logic [DATA_WIDTH-1:0] fq[$];
    logic                  rinc_s = 1'b0;

    always @(posedge rclk) begin
        #1;
        if (rinc_s && fq.size() != 0) void'(fq.pop_front());
        rempty = (fq.size() == 0);
        rdata  = (fq.size() != 0) ? fq[0] : '0;
    end

    // Behavioural model: buffer as a queue, counters as plain integers.
    logic [DATA_WIDTH-1:0] mq[$];
    int                    m_gap = 0;
    int                    m_cnt = 0;
    logic [DATA_WIDTH-1:0] m_exp = '0;
    logic                  m_err = 1'b0;
    bit                    m_pop;
    bit                    m_acc;

    always @(posedge rclk or posedge rrst) begin
        if (rrst) begin
            mq.delete();
            m_gap = 0;
            m_cnt = 0;
            m_exp = '0;
            m_err = 1'b0;
        end else begin
            m_pop = !rempty && (m_gap == 0) && (mq.size() < 2);
            m_acc = (mq.size() != 0) && m_ready;
            if (m_acc) void'(mq.pop_front());
            if (m_pop) mq.push_back(rdata);
            if (m_pop && throttle_en) m_gap = int'(throttle_gap);
            else if (m_gap > 0) m_gap = m_gap - 1;
            if (clr) begin
                m_cnt = 0;
                m_exp = '0;
                m_err = 1'b0;
            end else if (m_pop) begin
                if (chk_en && rdata != m_exp) m_err = 1'b1;
                m_cnt = (m_cnt + 1) % (1 << C_CNT_W);
                m_exp = m_exp + 1'b1;
            end
        end
    end

    // Compare process plus event logs for the directed checks.
    int                    cyc = 0;
    int                    pop_cyc[$];
    logic [DATA_WIDTH-1:0] pop_dat[$];
    logic [DATA_WIDTH-1:0] acc_log[$];
    int                    acc_cyc[$];
    int                    err_rise = -1;
    logic                  prev_err = 1'b0;
    bit                    mdl_rinc;

    always @(negedge rclk) begin
        cyc++;
        rinc_s   = rinc;
        mdl_rinc = !rrst && !rempty && (m_gap == 0) && (mq.size() < 2);
        chk("rinc", 32'(rinc), 32'(mdl_rinc));
        chk("m_valid", 32'(m_valid), 32'(mq.size() != 0));
        if (mq.size() != 0) chk("m_data", 32'(m_data), 32'(mq[0]));
        chk("rd_count", 32'(rd_count), 32'(m_cnt));
        chk("chk_err", 32'(chk_err), 32'(m_err));
        if (rinc) begin
            pop_cyc.push_back(cyc);
            pop_dat.push_back(rdata);
        end
        if (m_valid && m_ready) begin
            acc_log.push_back(m_data);
            acc_cyc.push_back(cyc);
        end
        if (chk_err === 1'b1 && prev_err !== 1'b1) err_rise = cyc;
        prev_err = chk_err;
    end

    task automatic step(input int n);
        repeat (n) @(posedge rclk);
        #2;
    endtask

    task automatic clear_logs();
        pop_cyc.delete();
        pop_dat.delete();
        acc_log.delete();
        acc_cyc.delete();
    endtask

    task automatic pulse_clr();
        clr = 1'b1;
        step(1);
        clr = 1'b0;
    endtask

    initial begin
        // Reset with words waiting in the FIFO
        #1;
        rrst    = 1'b1;
        chk_en  = 1'b1;
        m_ready = 1'b1;
        for (int i = 0; i < 8; i++) fq.push_back(DATA_WIDTH'(i));
        step(3);
        @(negedge rclk);
        chk("reset_rinc", 32'(rinc), 32'd0);
        chk("reset_m_valid", 32'(m_valid), 32'd0);
        chk("reset_rd_count", 32'(rd_count), 32'd0);
        chk("reset_m_data", 32'(m_data), 32'd0);
        @(posedge rclk);
        #2;
        clear_logs();
        rrst = 1'b0;
        @(negedge rclk);
        chk("release_rinc", 32'(rinc), 32'd1);

        // Streaming 0..7 at full throughput
        step(12);
        chk("stream_pops", 32'(pop_cyc.size()), 32'd8);
        chk("stream_words", 32'(acc_log.size()), 32'd8);
        for (int i = 0; i < 8 && i < acc_log.size(); i++) begin
            chk("stream_data", 32'(acc_log[i]), 32'(i));
            chk("stream_cycle", 32'(acc_cyc[i]), 32'(pop_cyc[0] + 1 + i));
        end
        chk("stream_count", 32'(rd_count), 32'd8);
        chk("stream_err", 32'(chk_err), 32'd0);

        // Backpressure
        pulse_clr();
        chk_en  = 1'b0;
        m_ready = 1'b0;
        clear_logs();
        for (int i = 0; i < 5; i++) fq.push_back(DATA_WIDTH'(10 + i));
        step(8);
        chk("bp_count", 32'(rd_count), 32'd2);
        chk("bp_rinc", 32'(rinc), 32'd0);
        chk("bp_valid", 32'(m_valid), 32'd1);
        chk("bp_data", 32'(m_data), 32'd10);
        chk("bp_fifo_left", 32'(fq.size()), 32'd3);
        m_ready = 1'b1;
        step(8);
        chk("bp_words", 32'(acc_log.size()), 32'd5);
        for (int i = 0; i < 5 && i < acc_log.size(); i++)
            chk("bp_order", 32'(acc_log[i]), 32'(10 + i));
        chk("bp_count_end", 32'(rd_count), 32'd5);

        // Throttle: gap of 3 gives pops 4 cycles apart
        pulse_clr();
        throttle_en  = 1'b1;
        throttle_gap = 4'd3;
        clear_logs();
        for (int i = 0; i < 4; i++) fq.push_back(DATA_WIDTH'(20 + i));
        step(20);
        chk("thr_pops", 32'(pop_cyc.size()), 32'd4);
        for (int i = 1; i < pop_cyc.size(); i++)
            chk("thr_spacing", 32'(pop_cyc[i] - pop_cyc[i-1]), 32'd4);
        chk("thr_count", 32'(rd_count), 32'd4);
        throttle_en = 1'b0;
        step(5);

        // Checker: 0,1,5,3 against expectation 0,1,2,3
        pulse_clr();
        chk_en   = 1'b1;
        clear_logs();
        err_rise = -1;
        fq.push_back(8'd0);
        fq.push_back(8'd1);
        fq.push_back(8'd5);
        fq.push_back(8'd3);
        step(8);
        chk("chk_err_set", 32'(chk_err), 32'd1);
        chk("chk_pops", 32'(pop_dat.size()), 32'd4);
        if (pop_dat.size() == 4) begin
            chk("chk_third_word", 32'(pop_dat[2]), 32'd5);
            chk("chk_rise_cycle", 32'(err_rise), 32'(pop_cyc[2] + 1));
        end
        clr = 1'b1;
        step(1);
        clr = 1'b0;
        @(negedge rclk);
        chk("clr_err", 32'(chk_err), 32'd0);
        chk("clr_count", 32'(rd_count), 32'd0);

        // Mid-stream reset with a full buffer
        chk_en  = 1'b0;
        m_ready = 1'b0;
        step(1);
        fq.push_back(8'd30);
        fq.push_back(8'd31);
        fq.push_back(8'd32);
        step(6);
        chk("mid_full_valid", 32'(m_valid), 32'd1);
        @(posedge rclk);
        #3;
        rrst = 1'b1;
        #1;
        chk("mid_rst_valid", 32'(m_valid), 32'd0);
        chk("mid_rst_data", 32'(m_data), 32'd0);
        chk("mid_rst_rinc", 32'(rinc), 32'd0);
        step(2);
        clear_logs();
        rrst    = 1'b0;
        m_ready = 1'b1;
        step(6);
        chk("mid_left_words", 32'(acc_log.size()), 32'd1);
        if (acc_log.size() != 0) chk("mid_left_data", 32'(acc_log[0]), 32'd32);

        // Counter wrap: 17 pops on a 4-bit counter
        pulse_clr();
        for (int i = 0; i < 17; i++) fq.push_back(DATA_WIDTH'(i));
        step(25);
        chk("wrap_count", 32'(rd_count), 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
